// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch time-keeping core.
// Optional lap/freeze feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_counter_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned DIGITS           = 4;
  localparam int unsigned CNT_W            = BCD_W * DIGITS;
  localparam int unsigned BCD_MAX          = 9;
  localparam int unsigned TICK_DIV_DEFAULT = 1000000;
  localparam int unsigned PRESC_W_DEFAULT  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Displayed time SS.cc, most significant digit first
  typedef struct packed {
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] cs_tens;
    logic [BCD_W-1:0] cs_ones;
  } bcd_count_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses in, time display and status out.
// Lap signals exist only when STOPWATCH_LAP_EN is defined.
interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  logic       start_stop;
  logic       clear;
  bcd_count_t digits;
  logic       running;
  logic       wrapped;
`ifdef STOPWATCH_LAP_EN
  logic       lap;
  logic       lap_active;
`endif

  // Controller side (buttons / test driver)
  modport master (
    output start_stop,
    output clear,
`ifdef STOPWATCH_LAP_EN
    output lap,
    input  lap_active,
`endif
    input  digits,
    input  running,
    input  wrapped
  );

  // Stopwatch core side
  modport slave (
    input  start_stop,
    input  clear,
`ifdef STOPWATCH_LAP_EN
    input  lap,
    output lap_active,
`endif
    output digits,
    output running,
    output wrapped
  );

endinterface

// File: rtl/stopwatch_counter_bcd_digit_inc.sv
// One BCD digit incrementer: adds inc_en, wraps past MAX to 0 and carries out.
module stopwatch_counter_bcd_digit_inc
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned MAX = BCD_MAX
) (
  input  logic [BCD_W-1:0] digit,
  input  logic             inc_en,
  output logic [BCD_W-1:0] digit_next,
  output logic             carry
);

  logic [BCD_W-1:0] sum;

  stopwatch_counter_csa #(.N(BCD_W)) u_add (
    .a  (digit),
    .b  ('0),
    .ci (inc_en),
    .s  (sum)
  );

  // Roll over at MAX; otherwise take the adder result (digit itself when idle)
  always_comb begin
    carry      = inc_en && (digit == BCD_W'(MAX));
    digit_next = carry ? '0 : sum;
  end

endmodule

// File: rtl/stopwatch_counter_csa.sv
// Shared N-bit adder used for every increment in the stopwatch (a + b + ci).
module stopwatch_counter_csa #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s
);

  // Carry-in enters as a zero-extended operand
  assign s = a + b + N'(ci);

endmodule

// File: rtl/stopwatch_counter.sv
// Run/pause/clear stopwatch core: prescaler makes a 10 ms tick that advances a
// 4-digit BCD count SS.cc. Define STOPWATCH_LAP_EN for the lap/freeze display.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned PRESC_W  = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  stopwatch_counter_if.slave bus
);

  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  state_t             state;
  state_t             state_next;
  logic               presc_clr;
  logic               count_clr;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_inc;
  logic [PRESC_W-1:0] presc_next;
  logic               tick;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_inc;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   display_next;
  logic [CNT_W-1:0]   digits_q;
  logic [DIGITS-1:0]  carry;
  logic               running_q;
  logic               wrapped_q;
`ifdef STOPWATCH_LAP_EN
  logic [CNT_W-1:0]   capture;
  logic [CNT_W-1:0]   capture_next;
  logic               lap_q;
  logic               lap_next;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state; clear outranks start_stop outside RUN and is ignored in RUN
  always_comb begin
    state_next = state;
    presc_clr  = 1'b0;
    count_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          presc_clr = 1'b1;
          count_clr = 1'b1;
        end else if (bus.start_stop) begin
          state_next = RUN;
          presc_clr  = 1'b1;
        end
      end
      RUN: begin
        if (bus.start_stop) state_next = PAUSE;
      end
      PAUSE: begin
        if (bus.clear) begin
          state_next = IDLE;
          presc_clr  = 1'b1;
          count_clr  = 1'b1;
        end else if (bus.start_stop) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  stopwatch_counter_csa #(.N(PRESC_W)) u_presc_add (
    .a  (presc),
    .b  ('0),
    .ci (1'b1),
    .s  (presc_inc)
  );

  assign tick = (state == RUN) && (presc == TICK_LAST);

  // Ripple the tick through the four digits, least significant first
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic inc_en;
    if (i == 0) begin : g_lsd
      assign inc_en = tick;
    end else begin : g_carry
      assign inc_en = carry[i-1];
    end
    stopwatch_counter_bcd_digit_inc #(.MAX(BCD_MAX)) u_digit (
      .digit      (count[i*BCD_W +: BCD_W]),
      .inc_en     (inc_en),
      .digit_next (count_inc[i*BCD_W +: BCD_W]),
      .carry      (carry[i])
    );
  end

  // Datapath next values: prescaler holds outside RUN so a pause keeps the partial period
  always_comb begin
    presc_next = presc;
    if (presc_clr)          presc_next = '0;
    else if (tick)          presc_next = '0;
    else if (state == RUN)  presc_next = presc_inc;
    count_next = count_clr ? '0 : count_inc;
`ifdef STOPWATCH_LAP_EN
    lap_next     = lap_q;
    capture_next = capture;
    if (count_clr) begin
      lap_next = 1'b0;
    end else if ((state == RUN) && bus.lap) begin
      if (!lap_q) begin
        lap_next     = 1'b1;
        capture_next = count;
      end else begin
        lap_next = 1'b0;
      end
    end
    display_next = lap_next ? capture_next : count_next;
`else
    display_next = count_next;
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      count     <= '0;
      digits_q  <= '0;
      running_q <= 1'b0;
      wrapped_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      capture   <= '0;
      lap_q     <= 1'b0;
`endif
    end else begin
      presc     <= presc_next;
      count     <= count_next;
      digits_q  <= display_next;
      running_q <= (state_next == RUN);
      wrapped_q <= carry[DIGITS-1];
`ifdef STOPWATCH_LAP_EN
      capture   <= capture_next;
      lap_q     <= lap_next;
`endif
    end
  end

  assign bus.digits  = digits_q;
  assign bus.running = running_q;
  assign bus.wrapped = wrapped_q;
`ifdef STOPWATCH_LAP_EN
  assign bus.lap_active = lap_q;
`endif

endmodule
